regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter.
// It merges unbuffered ALU results and queued load results onto a single
// registered write port. Loads pass through a 2-entry in-order FIFO. A
// starvation counter makes sure the load head cannot be locked out forever
// by a steady stream of ALU results.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_LIM = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_rd,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_rd,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    output logic                     write_enable,
    output logic [ADDR_W-1:0]        write_address,
    output logic [DATA_W-1:0]        write_data,
    output logic [(1<<ADDR_W)-1:0]   pending_mask
);

    localparam int NREG = 1 << ADDR_W;
    // STARVE_LIM is assumed to be at least 1.
    localparam int SW   = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    // Load FIFO storage. These entries are not reset. Validity comes only
    // from the count and the read pointer.
    logic [ADDR_W-1:0] fifo_rd_mem   [2];
    logic [DATA_W-1:0] fifo_data_mem [2];

    logic [1:0]        count_reg, count_next;
    logic              rd_ptr_reg, rd_ptr_next;
    logic              wr_ptr_reg, wr_ptr_next;
    logic [SW-1:0]     starve_cnt_reg, starve_cnt_next;

    logic              we_reg, we_next;
    logic [ADDR_W-1:0] waddr_reg, waddr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;

    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic              head_grant;
    logic              alu_grant;
    logic              push;
    logic              pop;
    logic [1:0]        slot_valid;

    assign fifo_empty = (count_reg == 2'd0);
    assign fifo_full  = (count_reg == 2'd2);
    assign head_rd    = fifo_rd_mem[rd_ptr_reg];
    assign head_data  = fifo_data_mem[rd_ptr_reg];

    // Single write slot. A full FIFO or a starved head preempts the ALU.
    // Otherwise the ALU has priority over a waiting load.
    always_comb begin
        head_grant = 1'b0;
        alu_grant  = 1'b0;
        if (!fifo_empty && (fifo_full || starve_cnt_reg == STARVE_MAX)) begin
            head_grant = 1'b1;
        end else if (alu_valid) begin
            alu_grant = 1'b1;
        end else if (!fifo_empty) begin
            head_grant = 1'b1;
        end
    end

    // The grant is combinational. It is forced low while reset is asserted
    // so that no ALU handshake can complete during reset.
    assign alu_ready = alu_grant & rst_n;
    assign ld_ready  = ~fifo_full;
    assign push      = ld_valid & ld_ready;
    assign pop       = head_grant;

    // FIFO bookkeeping, the starvation counter and the next write-port contents.
    always_comb begin
        count_next      = count_reg;
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;
        starve_cnt_next = '0;
        we_next         = 1'b0;
        waddr_next      = waddr_reg;
        wdata_next      = wdata_reg;

        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
        if (push) wr_ptr_next = ~wr_ptr_reg;
        if (pop)  rd_ptr_next = ~rd_ptr_reg;

        // The counter only advances while a load waits and loses the slot.
        if (!fifo_empty && !head_grant) begin
            starve_cnt_next = (starve_cnt_reg == STARVE_MAX) ? STARVE_MAX
                                                             : starve_cnt_reg + 1'b1;
        end

        // Writes to r0 are consumed silently. Address and data then hold.
        if (head_grant) begin
            if (head_rd != '0) begin
                we_next    = 1'b1;
                waddr_next = head_rd;
                wdata_next = head_data;
            end
        end else if (alu_grant) begin
            if (alu_rd != '0) begin
                we_next    = 1'b1;
                waddr_next = alu_rd;
                wdata_next = alu_data;
            end
        end
    end

    // Control state and the write port. Reset discards queued loads and any
    // write that was about to be issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg      <= 2'd0;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
            starve_cnt_reg <= '0;
            we_reg         <= 1'b0;
            waddr_reg      <= '0;
            wdata_reg      <= '0;
        end else begin
            count_reg      <= count_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            starve_cnt_reg <= starve_cnt_next;
            we_reg         <= we_next;
            waddr_reg      <= waddr_next;
            wdata_reg      <= wdata_next;
        end
    end

    // FIFO payload write. A pushed entry is only visible from the next cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]   <= ld_rd;
            fifo_data_mem[wr_ptr_reg] <= ld_data;
        end
    end

    assign write_enable  = we_reg;
    assign write_address = waddr_reg;
    assign write_data    = wdata_reg;

    // Mark which FIFO slots hold live entries, derived from count and read pointer.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_valid[gi] = fifo_full ||
                                    (count_reg == 2'd1 && rd_ptr_reg == 1'(gi));
        end
    endgenerate

    // Pending-destination scoreboard. r0 is never pending because it is never written.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_mask
            if (gi == 0) begin : g_r0
                assign pending_mask[gi] = 1'b0;
            end else begin : g_rn
                assign pending_mask[gi] =
                    (slot_valid[0] && fifo_rd_mem[0] == ADDR_W'(gi)) ||
                    (slot_valid[1] && fifo_rd_mem[1] == ADDR_W'(gi));
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter.
// A queue-based model runs alongside the design and checks every cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_regfile_wb_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LIM = 4;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [DW-1:0] write_data;
    logic [31:0]   pending_mask;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIM(LIM)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .ld_valid      (ld_valid),
        .ld_rd         (ld_rd),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .pending_mask  (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: the load queue, the count of lost rounds, and the write
    // expected on the next cycle.
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ld_t;

    ld_t           lq[$];
    ld_t           m_head;
    int            m_starve;
    int            m_n;
    logic          m_head_wins;
    logic          m_alu_wins;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [31:0]   exp_mask;

    // Per-cycle compare. Inputs are stable at the falling edge and equal what
    // the next rising edge samples, so the model advances here too.
    always @(negedge clk) begin
        if (!rst_n) begin
            lq.delete();
            m_starve = 0;
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
            check("rst_we",        write_enable,  0);
            check("rst_addr",      write_address, 0);
            check("rst_data",      write_data,    0);
            check("rst_alu_ready", alu_ready,     0);
            check("rst_ld_ready",  ld_ready,      1);
            check("rst_mask",      pending_mask,  0);
        end else begin
            m_n = lq.size();
            exp_mask = '0;
            foreach (lq[i]) if (lq[i].rd != 0) exp_mask[lq[i].rd] = 1'b1;
            m_head_wins = (m_n > 0) && (m_n == 2 || m_starve == LIM || !alu_valid);
            m_alu_wins  = alu_valid && !m_head_wins;

            check("mdl_alu_ready", alu_ready,    m_alu_wins);
            check("mdl_ld_ready",  ld_ready,     (m_n < 2));
            check("mdl_mask",      pending_mask, exp_mask);
            check("mdl_we",        write_enable, exp_we);
            if (exp_we) begin
                check("mdl_addr", write_address, exp_addr);
                check("mdl_data", write_data,    exp_data);
            end

            // Advance the model across the coming rising edge.
            exp_we = 1'b0;
            if (m_head_wins) begin
                m_head = lq.pop_front();
                if (m_head.rd != 0) begin
                    exp_we   = 1'b1;
                    exp_addr = m_head.rd;
                    exp_data = m_head.data;
                end
            end else if (m_alu_wins && alu_rd != 0) begin
                exp_we   = 1'b1;
                exp_addr = alu_rd;
                exp_data = alu_data;
            end
            if (m_n > 0 && !m_head_wins) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
            else                         m_starve = 0;
            if (ld_valid && m_n < 2) lq.push_back('{rd: ld_rd, data: ld_data});
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Directed vector table: alu_valid, alu_rd, ld_valid, ld_rd.
    int tab_av [12] = '{1, 1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    int tab_ar [12] = '{4, 8, 2, 0, 13, 0, 21, 0, 0, 30, 6, 0};
    int tab_lv [12] = '{1, 1, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0};
    int tab_lr [12] = '{17, 4, 0, 19, 0, 22, 0, 31, 0, 17, 0, 0};

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h2;

        // During reset: no ALU grant, FIFO reports space, no write.
        mid();
        check("reset_alu_ready", alu_ready, 0);
        check("reset_ld_ready",  ld_ready,  1);
        check("reset_we",        write_enable, 0);
        next_cycle();
        alu_valid = 1'b0; ld_valid = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // ALU-only write.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_A5A5;
        mid();
        check("alu_ready_c1", alu_ready, 1);
        next_cycle();
        alu_valid = 1'b0;
        mid();
        check("alu_we_c2",   write_enable,  1);
        check("alu_addr_c2", write_address, 3);
        check("alu_data_c2", write_data,    32'hA5A5_A5A5);
        next_cycle();

        // Load-only write.
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
        mid();
        check("ld_ready_c1", ld_ready, 1);
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check("ld_mask7_c2", pending_mask[7], 1);
        check("ld_we_c2",    write_enable, 0);
        next_cycle();
        mid();
        check("ld_we_c3",    write_enable,  1);
        check("ld_addr_c3",  write_address, 7);
        check("ld_data_c3",  write_data,    32'h11);
        check("ld_mask_c3",  pending_mask,  0);
        next_cycle();

        // Full FIFO with the ALU held busy, followed by starvation of the remaining load.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        ld_valid  = 1'b1; ld_rd  = 5'd5; ld_data  = 32'h55;
        mid();
        check("full_alu_a", alu_ready, 1);
        next_cycle();
        ld_rd = 5'd6; ld_data = 32'h66;
        mid();
        check("full_alu_b",   alu_ready, 1);
        check("full_ldrdy_b", ld_ready,  1);
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check("full_ld_ready", ld_ready,     0);
        check("full_alu_lose", alu_ready,    0);
        check("full_mask",     pending_mask, 32'h0000_0060);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            mid();
            check("starve_alu_win", alu_ready, 1);
            if (k == 0) begin
                check("full_head_we",   write_enable,  1);
                check("full_head_addr", write_address, 5);
                check("full_head_data", write_data,    32'h55);
            end
            next_cycle();
        end
        mid();
        check("starve_head_win", alu_ready,    0);
        check("starve_mask",     pending_mask, 32'h0000_0040);
        next_cycle();
        mid();
        check("starve_we",     write_enable,  1);
        check("starve_addr",   write_address, 6);
        check("starve_data",   write_data,    32'h66);
        check("starve_mask0",  pending_mask,  0);
        next_cycle();

        // A cleared counter means a fresh load again waits a full four lost rounds.
        ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'hC;
        next_cycle();
        ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            check("restarve_alu_win", alu_ready, 1);
            next_cycle();
        end
        mid();
        check("restarve_head_win", alu_ready, 0);
        next_cycle();
        alu_valid = 1'b0;
        mid();
        check("restarve_addr", write_address, 12);
        next_cycle();

        // ALU result to r0: handshake happens but nothing is written.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        mid();
        check("r0_alu_ready", alu_ready, 1);
        next_cycle();
        alu_valid = 1'b0;
        mid();
        check("r0_alu_we", write_enable, 0);
        next_cycle();

        // Load to r0: popped silently and never marked as pending.
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h77;
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check("r0_ld_mask", pending_mask, 0);
        next_cycle();
        mid();
        check("r0_ld_we", write_enable, 0);
        next_cycle();

        // Reset mid-flight with two loads queued.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
        ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data = 32'hA;
        next_cycle();
        ld_rd = 5'd11; ld_data = 32'hB;
        next_cycle();
        ld_valid = 1'b0;
        mid();
        check("rmid_mask_full", pending_mask, 32'h0000_0C00);
        check("rmid_ld_ready",  ld_ready,     0);
        rst_n = 1'b0; alu_valid = 1'b0;
        next_cycle();
        check("rmid_we_in_rst", write_enable, 0);
        mid();
        rst_n = 1'b1;
        mid();
        check("rmid_we_after",   write_enable, 0);
        check("rmid_ldrdy_after", ld_ready,    1);
        check("rmid_mask_after", pending_mask, 0);
        next_cycle();

        // Mixed directed vectors. The model checks every cycle.
        for (int i = 0; i < 12; i++) begin
            alu_valid = tab_av[i][0];
            alu_rd    = AW'(tab_ar[i]);
            alu_data  = 32'h1000_0000 + 32'(i);
            ld_valid  = tab_lv[i][0];
            ld_rd     = AW'(tab_lr[i]);
            ld_data   = 32'h2000_0000 + 32'(i);
            next_cycle();
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        repeat (4) next_cycle();
        mid();
        check("drain_mask",     pending_mask, 0);
        check("drain_ld_ready", ld_ready,     1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
